axi4_lite_master: RTL and testbench
===================================

# axi4_lite_master

AXI4-Lite initiator that turns single read/write commands from a simple valid/ready command port into AXI4-Lite transactions and returns the result on a response port. It drives the `axi4_gpio` slave, and any other AXI4-Lite register slave in the lenia fabric, from on-chip control logic. Exactly one transaction is outstanding at a time. A watchdog flags slaves that stall.

## Interface
- `ADDR_W`, 32: AXI and command address width.
- `DATA_W`, 32: data width. Fixed at 32; `wstrb` is `DATA_W/8`.
- `TIMEOUT`, 1024: number of stalled cycles in any AXI wait state before `timeout_err` is set. 0 disables the watchdog.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted on the edge where `cmd_valid && cmd_ready`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: target address, passed through unmodified.
- `cmd_wdata` in 32: write data.
- `cmd_wstrb` in 4: write byte strobes.
- `rsp_valid` out 1: result present.
- `rsp_ready` in 1: result consumed.
- `rsp_write` out 1: echoes `cmd_write` of the completed command.
- `rsp_rdata` out 32: read data. 0 for writes.
- `rsp_resp` out 2: BRESP or RRESP from the slave.
- `timeout_err` out 1: sticky watchdog flag.
- `axi_awaddr` out ADDR_W, `axi_awvalid` out 1, `axi_awready` in 1.
- `axi_wdata` out 32, `axi_wstrb` out 4, `axi_wvalid` out 1, `axi_wready` in 1.
- `axi_bresp` in 2, `axi_bvalid` in 1, `axi_bready` out 1.
- `axi_araddr` out ADDR_W, `axi_arvalid` out 1, `axi_arready` in 1.
- `axi_rdata` in 32, `axi_rresp` in 2, `axi_rvalid` in 1, `axi_rready` out 1.

## Operation

The block is a state machine with states IDLE, WRITE, WRESP, RADDR, RDATA, RESP.

- **IDLE**: `cmd_ready` = 1.
  - On accept, latch `addr`, `wdata`, `wstrb` and `write` into the AXI output registers.
  - Write command: go to WRITE and set `awvalid` = `wvalid` = 1.
  - Read command: go to RADDR and set `arvalid` = 1.
- **WRITE**: AW and W channels complete independently.
  - `awvalid` drops on the edge where `awvalid && awready`; `wvalid` drops on the edge where `wvalid && wready`.
  - Internal flags `aw_done` and `w_done` record each completion.
  - When both channels are done, in either order or on the same edge, go to WRESP.
- **WRESP**: `bready` = 1. On `bvalid`, capture `bresp` into `rsp_resp`, set `rsp_rdata` = 0 and `rsp_write` = 1, then go to RESP.
- **RADDR**: `arvalid` held until `arready`, then go to RDATA.
- **RDATA**: `rready` = 1. On `rvalid`, capture `rdata` and `rresp`, set `rsp_write` = 0, then go to RESP.
- **RESP**: `rsp_valid` = 1 and outputs stay stable. On `rsp_ready`, go to IDLE.

Protocol rules:
- Once asserted, a VALID is never withdrawn before its handshake.
- Address and data are stable while VALID is high.
- `bready` is asserted only in WRESP and `rready` only in RDATA.
- `rsp_resp` is reported as received; SLVERR and DECERR are not retried.

Watchdog:
- A counter clears on every state change and increments each cycle spent in WRITE, WRESP, RADDR or RDATA.
- When the count reaches `TIMEOUT`, `timeout_err` is set and stays at 1 until `reset`.
- The transaction is not abandoned; the block keeps waiting so the AXI protocol is preserved.
- The counter saturates and does not wrap.

## Timing
- Reset values: state IDLE, `cmd_ready` = 1, every AXI `*valid` and `*ready` = 0, `rsp_valid` = 0, `rsp_*` = 0, AXI address/data/strobe = 0, `timeout_err` = 0.
- Reset mid-transaction drops all VALIDs on the next edge and returns to IDLE. Reset is only legal while the slave is also reset.
- Accept on edge E0 → AXI VALIDs high after E0.
- Zero-wait write slave (`awready` = `wready` = 1, `bvalid` one cycle after W): AW/W handshake at E1, B handshake at E2, `rsp_valid` high after E2.
- Zero-wait read slave: AR handshake at E1, `rvalid` after E1, R handshake at E2, `rsp_valid` high after E2.
- RESP → IDLE on the `rsp_ready` edge, so `cmd_ready` returns one cycle later. Back-to-back throughput is at least 4 cycles per command.
- The `cmd_*` inputs are ignored outside IDLE.

## Test plan
- **Zero-wait write.** Slave always ready; write 0xA5A5A5A5 to address 0x0 with wstrb 0xF → one AW and one W handshake, `bready` for one cycle, `rsp_valid` 2 cycles after accept with `rsp_resp` = 00 and `rsp_write` = 1; the GPIO slave then reports `gpio_out` = 0xA5A5A5A5.
- **Zero-wait read.** Read 0x0 with `gpio_in` = 0xDEADBEEF → `rsp_rdata` = 0xDEADBEEF, `rsp_resp` = 00, `rsp_write` = 0.
- **Skewed write channels.** `wready` high 3 cycles before `awready` → `wvalid` drops after its handshake, `awvalid` is held until its own handshake, exactly one B phase occurs, response is correct.
- **Response backpressure.** Hold `rsp_ready` = 0 for 5 cycles → `rsp_*` stable throughout, `cmd_ready` = 0 throughout, a new command is accepted only after `rsp_ready`.
- **Error and watchdog.** Slave returns `rresp` = 10 → `rsp_resp` = 10. With `TIMEOUT` = 8 and `arready` held low for 20 cycles → `timeout_err` rises on cycle 8, `arvalid` stays 1, the transaction completes once `arready` is released, and `timeout_err` clears only on `reset`.
- **Reset during WRITE.** Assert `reset` while waiting on `awready` → all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/axi4_lite_master.sv
// axi4_lite_master: turns single read/write commands into AXI4-Lite
// transactions, one outstanding at a time, with a sticky stall watchdog.
//
// Handshake semantics (all ports): a transfer happens on the rising edge
// where valid && ready are both high; once a valid is raised it is held,
// with its payload stable, until that edge.
module axi4_lite_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  timeout_err,
  // AXI4-Lite write address / data / response
  output logic [ADDR_W-1:0]     axi_awaddr,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [DATA_W-1:0]     axi_wdata,
  output logic [DATA_W/8-1:0]   axi_wstrb,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  // AXI4-Lite read address / data
  output logic [ADDR_W-1:0]     axi_araddr,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [DATA_W-1:0]     axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  // debug view of the controller state
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state;
  logic             aw_done;
  logic             w_done;
  logic [CNT_W-1:0] wd_cnt;

  logic aw_fire;
  logic w_fire;
  logic aw_done_nxt;
  logic w_done_nxt;
  logic waiting;
  logic leaving;

  assign state_dbg   = state;
  assign aw_fire     = axi_awvalid & axi_awready;
  assign w_fire      = axi_wvalid & axi_wready;
  assign aw_done_nxt = aw_done | aw_fire;
  assign w_done_nxt  = w_done | w_fire;

  // Classify the current cycle for the watchdog: an AXI wait state, and
  // whether the state will change on the coming edge.
  always_comb begin
    waiting = 1'b0;
    leaving = 1'b0;
    case (state)
      S_WRITE: begin waiting = 1'b1; leaving = aw_done_nxt & w_done_nxt; end
      S_WRESP: begin waiting = 1'b1; leaving = axi_bvalid;  end
      S_RADDR: begin waiting = 1'b1; leaving = axi_arready; end
      S_RDATA: begin waiting = 1'b1; leaving = axi_rvalid;  end
      default: ;
    endcase
  end

  // Transaction controller; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      axi_awaddr  <= '0;
      axi_awvalid <= 1'b0;
      axi_wdata   <= '0;
      axi_wstrb   <= '0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      axi_araddr  <= '0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          // cmd_ready is high throughout IDLE, so cmd_valid alone accepts
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            if (cmd_write) begin
              axi_awaddr  <= cmd_addr;
              axi_wdata   <= cmd_wdata;
              axi_wstrb   <= cmd_wstrb;
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
              state       <= S_WRITE;
            end else begin
              axi_araddr  <= cmd_addr;
              axi_arvalid <= 1'b1;
              state       <= S_RADDR;
            end
          end
        end
        S_WRITE: begin
          // AW and W retire independently; leave once both have fired
          if (aw_fire) axi_awvalid <= 1'b0;
          if (w_fire)  axi_wvalid  <= 1'b0;
          aw_done <= aw_done_nxt;
          w_done  <= w_done_nxt;
          if (aw_done_nxt && w_done_nxt) begin
            axi_bready <= 1'b1;
            state      <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            rsp_resp   <= axi_bresp;
            rsp_rdata  <= '0;
            rsp_write  <= 1'b1;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RADDR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (axi_rvalid) begin
            axi_rready <= 1'b0;
            rsp_rdata  <= axi_rdata;
            rsp_resp   <= axi_rresp;
            rsp_write  <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  // Watchdog: count stalled cycles in an AXI wait state; flag is sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (!waiting || leaving) begin
      wd_cnt <= '0;
    end else begin
      if (wd_cnt != CNT_MAX) wd_cnt <= wd_cnt + 1'b1;
      if ((TIMEOUT != 0) && (wd_cnt == CNT_LAST)) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master: directed and random command sequence against a
// bench-side AXI4-Lite register slave and a word-array reference model.
module tb_axi4_lite_master;

  localparam int TO = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        timeout_err;
  logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [3:0]  axi_wstrb;
  logic [1:0]  axi_bresp, axi_rresp;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic        axi_rvalid, axi_rready;
  logic [2:0]  state_dbg;

  axi4_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout_err(timeout_err),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready), .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .state_dbg(state_dbg)
  );

  // scoreboard state
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] slave_mem [16];  // what the bench slave actually holds
  logic [31:0] ref_mem   [16];  // what the commands say it should hold
  logic        exp_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, 64'({cmd_ready, axi_awvalid, axi_wvalid, axi_bready,
                              axi_arvalid, axi_rready, rsp_valid, timeout_err}), 64'h80);
    check({tag, "_rsp"}, 64'({rsp_write, rsp_resp, rsp_rdata}), 64'h0);
    check({tag, "_addr"}, {axi_awaddr, axi_araddr}, 64'h0);
    check({tag, "_wdat"}, 64'({axi_wdata, axi_wstrb}), 64'h0);
  endtask

  // Drive one command and act as the AXI slave cycle by cycle. d1/d2/d3 are
  // AW/W/B delays for writes, AR/R delays for reads; resp is what the slave
  // returns; hold is the number of cycles rsp_ready is withheld.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int d1, input int d2, input int d3,
                         input logic [1:0] resp, input int hold, output int err_cyc);
    int n1, n2, n3, c1, c2, c3, viol, lat, exp_lat, waitc;
    bit got;
    logic        err_prev;
    logic [31:0] exp_rdata, s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_resp;
    logic        s_write;
    n1 = 0; n2 = 0; n3 = 0; c1 = 0; c2 = 0; c3 = 0; viol = 0; lat = -1;
    got = 0; err_cyc = -1; s_addr = '0; s_wdata = '0; s_wstrb = '0;
    // expected outcome from the reference model
    if (wr) begin
      exp_rdata = 32'h0;
      exp_lat   = ((d1 > d2) ? d1 : d2) + d3 + 2;
      if (resp == 2'b00)
        for (int b = 0; b < 4; b++)
          if (strb[b]) ref_mem[addr[5:2]][8*b +: 8] = data[8*b +: 8];
    end else begin
      exp_rdata = ref_mem[addr[5:2]];
      exp_lat   = d1 + d2 + 2;
    end
    // command phase
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    waitc = 0;
    while (!cmd_ready && waitc < 20) begin @(negedge clk); waitc++; end
    check("cmd_ready_idle", 64'(cmd_ready), 64'h1);
    @(negedge clk);
    // junk held on the command port must be ignored outside IDLE
    cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    err_prev = timeout_err;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cmd_ready) viol++;
      if (!err_prev && timeout_err && err_cyc < 0) err_cyc = cyc;
      if (wr) begin
        if (axi_arvalid || axi_rready) viol++;
        if ((n1 > 0) == axi_awvalid) viol++;
        if ((n2 > 0) == axi_wvalid) viol++;
        if (axi_awvalid && axi_awaddr !== addr) viol++;
        if (axi_wvalid && (axi_wdata !== data || axi_wstrb !== strb)) viol++;
        if (axi_bready && (n1 == 0 || n2 == 0 || n3 > 0)) viol++;
      end else begin
        if (axi_awvalid || axi_wvalid || axi_bready) viol++;
        if ((n1 > 0) == axi_arvalid) viol++;
        if (axi_arvalid && axi_araddr !== addr) viol++;
        if (axi_rready && (n1 == 0 || n2 > 0)) viol++;
      end
      if (rsp_valid) begin got = 1; lat = cyc; break; end
      if (wr) begin
        axi_bvalid = 1'b0;
        if (n1 > 0 && n2 > 0 && n3 == 0) begin
          if (c3 >= d3) begin axi_bvalid = 1'b1; axi_bresp = resp; end
          c3++;
          if (axi_bvalid && axi_bready) begin
            n3++;
            if (resp == 2'b00)
              for (int b = 0; b < 4; b++)
                if (s_wstrb[b]) slave_mem[s_addr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
          end
        end
        axi_awready = axi_awvalid && n1 == 0 && c1 >= d1;
        if (axi_awvalid && n1 == 0) c1++;
        if (axi_awready) begin n1++; s_addr = axi_awaddr; end
        axi_wready = axi_wvalid && n2 == 0 && c2 >= d2;
        if (axi_wvalid && n2 == 0) c2++;
        if (axi_wready) begin n2++; s_wdata = axi_wdata; s_wstrb = axi_wstrb; end
      end else begin
        axi_rvalid = 1'b0;
        if (n1 > 0 && n2 == 0) begin
          if (c2 >= d2) begin
            axi_rvalid = 1'b1; axi_rdata = slave_mem[s_addr[5:2]]; axi_rresp = resp;
          end
          c2++;
          if (axi_rvalid && axi_rready) n2++;
        end
        axi_arready = axi_arvalid && n1 == 0 && c1 >= d1;
        if (axi_arvalid && n1 == 0) c1++;
        if (axi_arready) begin n1++; s_addr = axi_araddr; end
      end
    end
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0;
    axi_arready = 1'b0; axi_rvalid = 1'b0;
    check("rsp_seen", 64'(got), 64'h1);
    check("latency", 64'(lat), 64'(exp_lat));
    check("protocol", 64'(viol), 64'h0);
    check("hs_counts", 64'({n1[7:0], n2[7:0], n3[7:0]}), wr ? 64'h010101 : 64'h010100);
    check("rsp_write", 64'(rsp_write), 64'(wr));
    check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    check("rsp_resp", 64'(rsp_resp), 64'(resp));
    // response backpressure: everything frozen while rsp_ready is low
    s_rdata = rsp_rdata; s_resp = rsp_resp; s_write = rsp_write; viol = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!rsp_valid || cmd_ready || rsp_rdata !== s_rdata ||
          rsp_resp !== s_resp || rsp_write !== s_write) viol++;
    end
    check("rsp_stable", 64'(viol), 64'h0);
    rsp_ready = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_release", 64'({rsp_valid, cmd_ready}), 64'h1);
    check("timeout_err", 64'(timeout_err), 64'(exp_err));
  endtask

  // global time bound
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "time limit");
  end

  // directed steps followed by random traffic
  initial begin
    int          ec;
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  resp;
    reset = 1'b1; exp_err = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bresp = 2'b00; axi_bvalid = 1'b0;
    axi_arready = 1'b0; axi_rdata = '0; axi_rresp = 2'b00; axi_rvalid = 1'b0;
    for (int i = 0; i < 16; i++) begin slave_mem[i] = '0; ref_mem[i] = '0; end
    repeat (3) @(negedge clk);
    check_reset("reset");
    reset = 1'b0;

    // zero-wait write then read-back
    run_txn(1, 32'h0, 32'hA5A5_A5A5, 4'hF, 0, 0, 0, 2'b00, 0, ec);
    run_txn(0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, ec);
    // zero-wait read of an externally driven register value
    slave_mem[1] = 32'hDEAD_BEEF; ref_mem[1] = 32'hDEAD_BEEF;
    run_txn(0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, ec);
    // skewed channels: W ready three cycles before AW; partial strobe
    run_txn(1, 32'h10, 32'h1122_3344, 4'b0101, 3, 0, 1, 2'b00, 0, ec);
    run_txn(0, 32'h10, 32'h0, 4'h0, 1, 2, 0, 2'b00, 0, ec);
    // response backpressure for five cycles
    run_txn(1, 32'h14, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 2'b00, 5, ec);
    run_txn(0, 32'h14, 32'h0, 4'h0, 0, 0, 0, 2'b00, 5, ec);
    // error responses are reported as received
    run_txn(0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 2'b10, 0, ec);
    run_txn(1, 32'h0, 32'h0BAD_0BAD, 4'hF, 1, 1, 1, 2'b10, 0, ec);
    run_txn(0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, ec);

    // random traffic with short stalls
    for (int t = 0; t < 30; t++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 15)) << 2;
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_txn(wr, addr, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              resp, $urandom_range(0, 3), ec);
    end

    // watchdog: AR stalls 20 cycles, flag must rise after TO stalled cycles
    exp_err = 1'b1;
    run_txn(0, 32'h4, 32'h0, 4'h0, 20, 1, 0, 2'b00, 0, ec);
    check("wd_rise_cycle", 64'(ec), 64'(TO));
    // flag stays set across later traffic
    run_txn(1, 32'h8, $urandom, 4'hF, 2, 1, 0, 2'b00, 1, ec);

    // reset while waiting on awready
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wait_valids", 64'({axi_awvalid, axi_wvalid, cmd_ready}), 64'h6);
    reset = 1'b1;
    @(negedge clk);
    check_reset("rst_mid");
    reset = 1'b0; exp_err = 1'b0;
    @(negedge clk);
    check_reset("rst_after");
    run_txn(0, 32'h20, 32'h0, 4'h0, 0, 1, 0, 2'b00, 0, ec);
    run_txn(1, 32'h3C, $urandom, 4'hF, 0, 2, 1, 2'b00, 2, ec);
    run_txn(0, 32'h3C, 32'h0, 4'h0, 2, 0, 0, 2'b00, 0, ec);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
